// File: rtl/memory_access_stage_if.sv
// Execute-to-memory stage bus: execute-stage request, write-back result and debug read port.
interface memory_access_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] result_in;
  logic [3:0]        reg_addr_in;
  logic              write_enable_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic              store_enable_in;
  logic              load_enable_in;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        wb_reg_addr;
  logic              wb_write_enable;
  logic              stall;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output result_in, reg_addr_in, write_enable_in, mem_addr_in,
    output store_enable_in, load_enable_in, dbg_addr,
    input  wb_data, wb_reg_addr, wb_write_enable, stall, dbg_data
  );

  modport slave (
    input  result_in, reg_addr_in, write_enable_in, mem_addr_in,
    input  store_enable_in, load_enable_in, dbg_addr,
    output wb_data, wb_reg_addr, wb_write_enable, stall, dbg_data
  );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage with a small resettable data memory.
// Define MEM_LOAD_WAIT_EN to give loads a one-cycle LOAD_WAIT bubble with stall.
module memory_access_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  memory_access_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              accept;
  logic              do_store;
  logic              do_load;

  assign rd_word      = mem[bus.mem_addr_in];
  assign bus.dbg_data = mem[bus.dbg_addr];

  // Store wins when both enables are set; the load is dropped.
  assign do_store = accept & bus.store_enable_in;
  assign do_load  = accept & bus.load_enable_in & ~bus.store_enable_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_store) begin
      mem[bus.mem_addr_in] <= bus.result_in;
    end
  end

`ifdef MEM_LOAD_WAIT_EN
  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t            state, state_nxt;
  logic              stall_nxt;
  logic [DATA_W-1:0] hold_data;
  logic [3:0]        hold_reg;
  logic              hold_we;

  assign accept    = (state == IDLE);
  assign bus.stall = stall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_nxt = 1'b0;
    case (state)
      IDLE:      if (do_load) state_nxt = LOAD_WAIT;
      LOAD_WAIT: begin
        stall_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // The load word is captured at acceptance so the bubble cycle cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_data         <= '0;
      bus.wb_reg_addr     <= '0;
      bus.wb_write_enable <= 1'b0;
      hold_data           <= '0;
      hold_reg            <= '0;
      hold_we             <= 1'b0;
    end else if (state == LOAD_WAIT) begin
      bus.wb_data         <= hold_data;
      bus.wb_reg_addr     <= hold_reg;
      bus.wb_write_enable <= hold_we;
    end else if (do_store) begin
      bus.wb_write_enable <= 1'b0;
    end else if (do_load) begin
      hold_data           <= rd_word;
      hold_reg            <= bus.reg_addr_in;
      hold_we             <= bus.write_enable_in;
      bus.wb_write_enable <= 1'b0;
    end else begin
      bus.wb_data         <= bus.result_in;
      bus.wb_reg_addr     <= bus.reg_addr_in;
      bus.wb_write_enable <= bus.write_enable_in;
    end
  end
`else
  // Single-cycle build: the stage never leaves IDLE.
  assign accept    = 1'b1;
  assign bus.stall = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_data         <= '0;
      bus.wb_reg_addr     <= '0;
      bus.wb_write_enable <= 1'b0;
    end else if (do_store) begin
      bus.wb_write_enable <= 1'b0;
    end else if (do_load) begin
      bus.wb_data         <= rd_word;
      bus.wb_reg_addr     <= bus.reg_addr_in;
      bus.wb_write_enable <= bus.write_enable_in;
    end else begin
      bus.wb_data         <= bus.result_in;
      bus.wb_reg_addr     <= bus.reg_addr_in;
      bus.wb_write_enable <= bus.write_enable_in;
    end
  end
`endif
endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: driver pushes expected write-back per edge, monitor pops and compares.
module tb_memory_access_stage;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_access_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
  memory_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          chk_data;
    bit          we;
    logic [15:0] data;
    logic [3:0]  ra;
    bit          stall;
    logic [3:0]  da;
    logic [15:0] dd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] mdl [16];
  int          nvec = 0;
  int          nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("wb_write_enable", 32'(bus.wb_write_enable), 32'(mon_e.we));
      check("stall", 32'(bus.stall), 32'(mon_e.stall));
      if (mon_e.chk_data) begin
        check("wb_data", 32'(bus.wb_data), 32'(mon_e.data));
        check("wb_reg_addr", 32'(bus.wb_reg_addr), 32'(mon_e.ra));
      end
      check("dbg_data", 32'(bus.dbg_data), 32'(mon_e.dd));
    end
  end

  task automatic drive(input bit st, input bit ld, input bit we, input logic [3:0] ra,
                       input logic [3:0] ma, input logic [15:0] res);
    bus.store_enable_in = st;
    bus.load_enable_in  = ld;
    bus.write_enable_in = we;
    bus.reg_addr_in     = ra;
    bus.mem_addr_in     = ma;
    bus.result_in       = res;
    bus.dbg_addr        = 4'($urandom);
  endtask

  task automatic drive_garbage();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
  endtask

  task automatic finish_rec(inout exp_t e);
    e.da = bus.dbg_addr;
    e.dd = mdl[bus.dbg_addr];
    sb.push_back(e);
  endtask

  // One operation as seen by the pipeline; a store wins over a simultaneous load.
  task automatic issue(input bit st, input bit ld, input bit we, input logic [3:0] ra,
                       input logic [3:0] ma, input logic [15:0] res);
    exp_t        e;
    logic [15:0] ld_d;
    @(negedge clk);
    drive(st, ld, we, ra, ma, res);
    e.data = '0; e.ra = '0; e.chk_data = 0; e.we = 0; e.stall = 0;
    if (st) begin
      mdl[ma] = res;
    end else if (ld) begin
      ld_d = mdl[ma];
`ifdef MEM_LOAD_WAIT_EN
      e.stall = 1;
      finish_rec(e);
      @(negedge clk);
      drive_garbage();
      e.stall = 0;
`endif
      e.chk_data = 1; e.we = we; e.data = ld_d; e.ra = ra;
    end else begin
      e.chk_data = 1; e.we = we; e.data = res; e.ra = ra;
    end
    finish_rec(e);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wb_write_enable"}, 32'(bus.wb_write_enable), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check({tag, "_wb_data"}, 32'(bus.wb_data), 32'd0);
    check({tag, "_wb_reg_addr"}, 32'(bus.wb_reg_addr), 32'd0);
    for (int a = 0; a < 16; a++) begin
      bus.dbg_addr = 4'(a);
      #0.1;
      check({tag, "_dbg_data"}, 32'(bus.dbg_data), 32'd0);
    end
  endtask

  // Asynchronous reset mid-stream; with the wait build it lands inside LOAD_WAIT.
  task automatic reset_mid();
`ifdef MEM_LOAD_WAIT_EN
    exp_t e;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'd6, 4'd3, 16'h0);
    e.data = '0; e.ra = '0; e.chk_data = 0; e.we = 0; e.stall = 1;
    finish_rec(e);
`else
    issue(1'b0, 1'b1, 1'b1, 4'd6, 4'd3, 16'h0);
`endif
    @(negedge clk);
    drive_garbage();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    reset_checks("mid_reset");
    check("mid_reset_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) issue(1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 16'($urandom));
  endtask

  task automatic random_ops(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 3);
      issue(r == 0 || r == 3, r == 1 || r == 3, 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
    repeat (2) @(negedge clk);
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 16'hBEEF);
    issue(1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 16'h0000);
    issue(1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 16'h1234);
    issue(1'b1, 1'b1, 1'b1, 4'd9, 4'd7, 16'h00AA);
    issue(1'b0, 1'b1, 1'b1, 4'd4, 4'd7, 16'h0000);
    issue(1'b1, 1'b0, 1'b1, 4'd1, 4'd15, 16'hFFFF);
    issue(1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 16'h5555);

    random_ops(400);
    reset_mid();
    random_ops(200);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 16, data/result width.
REQ-002 The block SHALL provide parameter ADDR_W, default 4, data-memory address width; depth = 2**ADDR_W (16 words).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port result_in, input, DATA_W, execute-stage result; store data or ALU/immediate value.
REQ-006 The block SHALL have port reg_addr_in, input, 4, destination register.
REQ-007 The block SHALL have port write_enable_in, input, 1, register write request.
REQ-008 The block SHALL have port mem_addr_in, input, ADDR_W, data-memory address.
REQ-009 The block SHALL have port store_enable_in, input, 1, store request.
REQ-010 The block SHALL have port load_enable_in, input, 1, load request.
REQ-011 The block SHALL have port wb_data, output, DATA_W, registered write-back data.
REQ-012 The block SHALL have port wb_reg_addr, output, 4, registered write-back register address.
REQ-013 The block SHALL have port wb_write_enable, output, 1, registered register-file write strobe.
REQ-014 The block SHALL have port stall, output, 1, upstream hold request; upstream keeps all inputs stable while high.
REQ-015 The block SHALL have port dbg_addr, input, ADDR_W, debug read address.
REQ-016 The block SHALL have port dbg_data, output, DATA_W, combinational read of mem[dbg_addr].

Function
REQ-017 The block SHALL contain a 2**ADDR_W x DATA_W data memory, written only by stores.
REQ-018 The block SHALL accept inputs on every rising edge where stall is low.
REQ-019 On an accepted store, mem[mem_addr_in] SHALL take result_in at that edge; wb_write_enable SHALL be 0 next cycle regardless of write_enable_in.
REQ-020 On an accepted load, wb_data SHALL equal the memory word at mem_addr_in, as the contents stood before that edge; wb_reg_addr = reg_addr_in; wb_write_enable = write_enable_in.
REQ-021 On an accepted non-memory operation (neither enable), wb_data = result_in, wb_reg_addr = reg_addr_in, wb_write_enable = write_enable_in, one cycle latency.
REQ-022 With store_enable_in and load_enable_in both high, the store SHALL execute and the load SHALL be ignored (REQ-019 applies).
REQ-023 A store at edge N followed by a load of the same address at edge N+1 SHALL return the newly stored value.
REQ-024 The FSM SHALL have states IDLE and LOAD_WAIT; stall = 1 exactly while in LOAD_WAIT; only IDLE exists when REQ-032 is disabled.
REQ-025 The address SHALL be ADDR_W bits; no wrap logic or out-of-range handling is required, since every value addresses a valid word.

Reset
REQ-026 While rst_n is low: wb_data = 0, wb_reg_addr = 0, wb_write_enable = 0, stall = 0, FSM = IDLE, all memory words = 0.
REQ-027 Reset assertion SHALL take effect immediately, without a clock edge; deassertion is applied synchronously to clk by the system.
REQ-028 Reset during LOAD_WAIT SHALL abort the load; no write-back SHALL occur for it after release.
REQ-029 dbg_data SHALL read 0 for every address during and immediately after reset.

Configuration
REQ-030 The block SHALL recognise macro MEM_LOAD_WAIT_EN.
REQ-031 Without MEM_LOAD_WAIT_EN, every operation SHALL complete in one cycle and stall SHALL be constant 0.
REQ-032 With MEM_LOAD_WAIT_EN, an accepted load SHALL enter LOAD_WAIT for one cycle, with stall = 1 and wb_write_enable = 0 (bubble).
REQ-033 In that case the load result SHALL appear on the second edge after acceptance; inputs SHALL be ignored in LOAD_WAIT.
REQ-034 With MEM_LOAD_WAIT_EN, stores and non-memory operations SHALL remain single-cycle.

Verification
REQ-035 Reset then dbg_addr=0..15 -> dbg_data=0x0000 for all; wb_write_enable=0, stall=0.
REQ-036 Store result_in=0xBEEF to addr 3, then next cycle load addr 3 to reg 5 with write_enable_in=1 -> wb_data=0xBEEF, wb_reg_addr=5, wb_write_enable=1.
REQ-037 ADD pass-through result_in=0x1234 to reg 2, write_enable_in=1 -> wb_data=0x1234 and wb_reg_addr=2 one cycle later; memory unchanged.
REQ-038 store_enable_in and load_enable_in both set, addr 7, result_in=0x00AA -> mem[7]=0x00AA, wb_write_enable=0.
REQ-039 MEM_LOAD_WAIT_EN defined, load addr 3 (holding 0xBEEF) -> stall=1 for exactly one cycle, then wb_data=0xBEEF with wb_write_enable=1.
REQ-040 MEM_LOAD_WAIT_EN defined, rst_n pulsed low during LOAD_WAIT -> stall=0 immediately, and no write-back pulse after release.
